decode_stage: RTL

Instruction-decode stage of the five-stage pipeline, directly downstream of the fetch stage. It accepts `instr`/`nextPc` from fetch and holds the 8×16 register file. A per-register pending-write scoreboard detects RAW hazards; on a hazard the stage stalls fetch and issues NOP bubbles. It drives the ID/EX pipeline register.

---
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// ============================================================================
// decode_stage_if : fetch/write-back inputs and ID/EX outputs of decode_stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface decode_stage_if;
    logic [15:0] instr;
    logic [15:0] nextPc;
    logic        doBranch;
    logic        downStall;
    logic        wbEn;
    logic [2:0]  wbReg;
    logic [15:0] wbData;
    logic [15:0] exInstr;
    logic [15:0] exPc;
    logic [15:0] rsData;
    logic [15:0] rtData;
    logic [2:0]  dstReg;
    logic        dstEn;
    logic        stallOut;
    logic        haltOut;
    logic        err;

    modport slave (
        input  instr, nextPc, doBranch, downStall, wbEn, wbReg, wbData,
        output exInstr, exPc, rsData, rtData, dstReg, dstEn, stallOut, haltOut, err
    );

    modport master (
        output instr, nextPc, doBranch, downStall, wbEn, wbReg, wbData,
        input  exInstr, exPc, rsData, rtData, dstReg, dstEn, stallOut, haltOut, err
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : register file, RAW scoreboard and ID/EX pipeline register
// Revision 1.0
// ============================================================================
`default_nettype none

module decode_stage (
    input  wire logic      clk,
    input  wire logic      rst,
    decode_stage_if.slave  bus
);

    localparam logic [15:0] c_NOP  = 16'h0800;
    localparam logic [4:0]  c_HALT = 5'b00000;

    logic [15:0] r_regs [8];
    logic [1:0]  r_pend [8];
    logic [1:0]  w_pend_nxt [8];
    logic        r_err;
    logic        w_underflow;

    logic [4:0]  w_op;
    logic [2:0]  w_ra, w_rb, w_rc, w_dst;
    logic        w_use_a, w_use_b, w_has_dst;
    logic [15:0] w_rs, w_rt;
    logic        w_hit_a, w_hit_b;
    logic        w_hazard, w_issue;
    logic [7:0]  w_inc_vec, w_dec_vec;

    logic [15:0] r_ex_instr, r_ex_pc, r_rs, r_rt;
    logic [2:0]  r_dst;
    logic        r_dst_en, r_halt;

    function automatic logic f_src_blocked(input logic [1:0] cnt, input logic wb_hit);
        return (cnt >= 2'd2) || ((cnt == 2'd1) && !wb_hit);
    endfunction

    assign w_op = bus.instr[15:11];
    assign w_ra = bus.instr[10:8];
    assign w_rb = bus.instr[7:5];
    assign w_rc = bus.instr[4:2];

    always_comb begin
        w_use_a   = 1'b0;
        w_use_b   = 1'b0;
        w_has_dst = 1'b0;
        w_dst     = 3'd0;
        casez (w_op)
            5'b1101?: begin w_use_a = 1'b1; w_use_b = 1'b1; w_has_dst = 1'b1; w_dst = w_rc; end
            5'b010??,
            5'b101??: begin w_use_a = 1'b1; w_has_dst = 1'b1; w_dst = w_rb; end
            5'b10000: begin w_use_a = 1'b1; w_use_b = 1'b1; end
            5'b10001: begin w_use_a = 1'b1; w_has_dst = 1'b1; w_dst = w_rb; end
            5'b10011: begin w_use_a = 1'b1; w_use_b = 1'b1; w_has_dst = 1'b1; w_dst = w_ra; end
            5'b011??,
            5'b00101: begin w_use_a = 1'b1; end
            5'b11000: begin w_has_dst = 1'b1; w_dst = w_ra; end
            5'b10010: begin w_use_a = 1'b1; w_has_dst = 1'b1; w_dst = w_ra; end
            5'b00110: begin w_has_dst = 1'b1; w_dst = 3'd7; end
            5'b00111: begin w_use_a = 1'b1; w_has_dst = 1'b1; w_dst = 3'd7; end
            default:  begin end
        endcase
    end

    // Write-before-read bypass lets a consumer issue in its producer's write-back cycle
    assign w_hit_a = bus.wbEn && (bus.wbReg == w_ra);
    assign w_hit_b = bus.wbEn && (bus.wbReg == w_rb);
    assign w_rs    = w_hit_a ? bus.wbData : r_regs[w_ra];
    assign w_rt    = w_hit_b ? bus.wbData : r_regs[w_rb];

    assign w_hazard = (w_use_a && f_src_blocked(r_pend[w_ra], w_hit_a))
                    | (w_use_b && f_src_blocked(r_pend[w_rb], w_hit_b))
                    | (w_has_dst && (r_pend[w_dst] == 2'd3));

    assign w_issue      = !bus.downStall && !bus.doBranch && !w_hazard;
    assign bus.stallOut = bus.downStall | (w_hazard & ~bus.doBranch);

    assign w_inc_vec = (w_issue && w_has_dst) ? (8'd1 << w_dst) : 8'd0;
    assign w_dec_vec = bus.wbEn ? (8'd1 << bus.wbReg) : 8'd0;

    always_comb begin
        w_underflow = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_pend_nxt[i] = r_pend[i];
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
                w_pend_nxt[i] = r_pend[i] + 2'd1;
            end else if (!w_inc_vec[i] && w_dec_vec[i]) begin
                if (r_pend[i] == 2'd0) begin
                    w_underflow = 1'b1;
                end else begin
                    w_pend_nxt[i] = r_pend[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_pend[i] <= 2'd0;
                r_regs[i] <= 16'd0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
            if (bus.wbEn) begin
                r_regs[bus.wbReg] <= bus.wbData;
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_instr <= c_NOP;
            r_ex_pc    <= 16'd0;
            r_rs       <= 16'd0;
            r_rt       <= 16'd0;
            r_dst      <= 3'd0;
            r_dst_en   <= 1'b0;
            r_halt     <= 1'b0;
        end else if (!bus.downStall) begin
            if (w_issue) begin
                r_ex_instr <= bus.instr;
                r_ex_pc    <= bus.nextPc;
                r_rs       <= w_rs;
                r_rt       <= w_rt;
                r_dst      <= w_dst;
                r_dst_en   <= w_has_dst;
                r_halt     <= (w_op == c_HALT);
            end else begin
                r_ex_instr <= c_NOP;
                r_ex_pc    <= 16'd0;
                r_rs       <= 16'd0;
                r_rt       <= 16'd0;
                r_dst      <= 3'd0;
                r_dst_en   <= 1'b0;
                r_halt     <= 1'b0;
            end
        end
    end

    assign bus.exInstr = r_ex_instr;
    assign bus.exPc    = r_ex_pc;
    assign bus.rsData  = r_rs;
    assign bus.rtData  = r_rt;
    assign bus.dstReg  = r_dst;
    assign bus.dstEn   = r_dst_en;
    assign bus.haltOut = r_halt;
    assign bus.err     = r_err;

endmodule

`default_nettype wire
